// File: rtl/cpu_flags_pkg.sv
// Shared NZCV flag bit positions, condition-code encodings and the result-stage state type.
package cpu_flags_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_t;
endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational condition-code evaluator: (NZCV flags, 4-bit cond) -> pass.
module cond_eval
  import cpu_flags_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register with shadow copy, registered condition-evaluation result and pass/fail stats.
// Define FLAG_BYPASS_EN to evaluate same-cycle queries against the incoming flag value instead of stalling.
module cond_flag_unit
  import cpu_flags_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [3:0] FLAG_RST = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  input  logic             upd_s,
  input  logic [3:0]       upd_flags,
  input  logic             save_en,
  input  logic             restore_en,
  input  logic             q_valid,
  input  logic [3:0]       q_cond,
  output logic             q_ready,
  output logic             r_valid,
  output logic             r_pass,
  output logic [3:0]       r_cond,
  input  logic             r_ready,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  res_state_t state;
  logic [3:0] shadow;
  logic [3:0] flags_next;
  logic [3:0] eval_flags;
  logic       flag_wr;
  logic       hazard;
  logic       accept;
  logic       eval_pass;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign flag_wr    = restore_en | (upd_valid & upd_s);
  assign flags_next = restore_en ? shadow : ((upd_valid & upd_s) ? upd_flags : flags);

`ifdef FLAG_BYPASS_EN
  assign hazard     = 1'b0;
  assign eval_flags = flags_next;
`else
  // Queries stall while flags are being written, so committed flags are always current.
  assign hazard     = flag_wr;
  assign eval_flags = flags;
`endif

  assign q_ready = ((state == RES_EMPTY) | r_ready) & !hazard;
  assign accept  = q_valid & q_ready;

  cond_eval u_eval (
    .flags (eval_flags),
    .cond  (q_cond),
    .pass  (eval_pass)
  );

  // Flag and shadow registers; shadow captures pre-update flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags  <= FLAG_RST;
      shadow <= 4'h0;
    end else begin
      flags <= flags_next;
      if (save_en) shadow <= flags;
    end
  end

  // Result stage: EMPTY/FULL with registered r_* outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RES_EMPTY;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_cond  <= 4'h0;
    end else begin
      unique case (state)
        RES_EMPTY: begin
          if (accept) begin
            state   <= RES_FULL;
            r_valid <= 1'b1;
            r_pass  <= eval_pass;
            r_cond  <= q_cond;
          end
        end
        RES_FULL: begin
          if (r_ready) begin
            if (accept) begin
              r_pass <= eval_pass;
              r_cond <= q_cond;
            end else begin
              state   <= RES_EMPTY;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          state   <= RES_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Statistics on consumed results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (r_valid && r_ready) begin
      if (r_pass) pass_cnt <= sat_inc(pass_cnt);
      else        fail_cnt <= sat_inc(fail_cnt);
    end
  end
endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomized and directed bench for cond_flag_unit against a cycle-level behavioural model.
module tb_cond_flag_unit;
  localparam int CNT_W = 2;
`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             upd_valid = 1'b0, upd_s = 1'b0, save_en = 1'b0, restore_en = 1'b0;
  logic [3:0]       upd_flags = 4'h0, q_cond = 4'h0;
  logic             q_valid = 1'b0, r_ready = 1'b0;
  logic             q_ready, r_valid, r_pass;
  logic [3:0]       r_cond, flags;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  int total = 0;
  int bad = 0;

  // Model state
  int m_flags, m_shadow, m_held, m_pass, m_cond, m_pc, m_fc;

  cond_flag_unit #(.CNT_W(CNT_W), .FLAG_RST(4'h0)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_s(upd_s), .upd_flags(upd_flags),
    .save_en(save_en), .restore_en(restore_en), .q_valid(q_valid), .q_cond(q_cond),
    .q_ready(q_ready), .r_valid(r_valid), .r_pass(r_pass), .r_cond(r_cond),
    .r_ready(r_ready), .flags(flags), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic int cond_ok(input int f, input int c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_r_valid"}, 32'(r_valid), 32'(m_held));
    chk({tag, "_r_pass"}, 32'(r_pass), 32'(m_pass));
    chk({tag, "_r_cond"}, 32'(r_cond), 32'(m_cond));
    chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(m_pc));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(m_fc));
  endtask

  task automatic model_reset();
    m_flags = 0; m_shadow = 0; m_held = 0; m_pass = 0; m_cond = 0; m_pc = 0; m_fc = 0;
  endtask

  // Called away from the clock edge; asserts rst asynchronously, then releases it.
  task automatic do_reset();
    upd_valid = 0; upd_s = 0; save_en = 0; restore_en = 0; q_valid = 0; r_ready = 0;
    rst = 1'b1;
    #1;
    model_reset();
    chk_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk_outputs("reset_rel");
  endtask

  // One clock cycle of stimulus; starts and ends shortly after a rising edge.
  task automatic step(input bit uv, input bit us, input int uf, input bit sv, input bit rs,
                      input bit qv, input int qc, input bit rr);
    int  nxt;
    bit  qr, acc;
    upd_valid = uv; upd_s = us; upd_flags = 4'(uf); save_en = sv; restore_en = rs;
    q_valid = qv; q_cond = 4'(qc); r_ready = rr;
    nxt = rs ? m_shadow : ((uv && us) ? uf : m_flags);
    qr  = (m_held == 0 || rr) && !(!BYP && (rs || (uv && us)));
    #1;
    chk("q_ready", 32'(q_ready), 32'(qr));
    @(posedge clk);
    acc = qv && qr;
    if (m_held != 0 && rr) begin
      if (m_pass != 0) m_pc = (m_pc < CNT_MAX) ? m_pc + 1 : m_pc;
      else             m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
      m_held = 0;
    end
    if (acc) begin
      m_held = 1;
      m_pass = cond_ok(BYP ? nxt : m_flags, qc);
      m_cond = qc;
    end
    if (sv) m_shadow = m_flags;
    m_flags = nxt;
    #2;
    chk_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // 1: NE / EQ on reset flags
    step(0, 0, 0, 0, 0, 1, 1, 1);
    chk("t1_ne_pass", 32'(r_pass), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    chk("t1_eq_pass", 32'(r_pass), 32'd0);
    idle(1);

    // 2: S gating
    step(1, 0, 4'h4, 0, 0, 0, 0, 1);
    chk("t2_no_s", 32'(flags), 32'h0);
    step(1, 1, 4'h4, 0, 0, 0, 0, 1);
    chk("t2_s", 32'(flags), 32'h4);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    chk("t2_eq", 32'(r_pass), 32'd1);
    idle(1);

    // 3: signed compares
    step(1, 1, 4'h9, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 4'hA, 1); chk("t3_ge", 32'(r_pass), 32'd1);
    step(0, 0, 0, 0, 0, 1, 4'hB, 1); chk("t3_lt", 32'(r_pass), 32'd0);
    step(0, 0, 0, 0, 0, 1, 4'hC, 1); chk("t3_gt", 32'(r_pass), 32'd1);
    step(1, 1, 4'hD, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 4'hC, 1); chk("t3_gt_z", 32'(r_pass), 32'd0);
    step(0, 0, 0, 0, 0, 1, 4'hD, 1); chk("t3_le", 32'(r_pass), 32'd1);
    idle(1);

    // 4: backpressure holds the result
    step(0, 0, 0, 0, 0, 1, 4'hE, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 4'hF, 0);
    chk("t4_held_cond", 32'(r_cond), 32'hE);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // 5: same-cycle S-update with EQ query (model covers both build variants)
    step(1, 1, 4'h0, 0, 0, 0, 0, 1);
    step(1, 1, 4'h4, 0, 0, 1, 0, 1);
    if (!BYP) step(0, 0, 0, 0, 0, 1, 0, 1);
    chk("t5_eq", 32'(r_pass), 32'd1);
    idle(1);

    // 6: save / restore, and saturation
    step(1, 1, 4'h2, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 1, 4'hF, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    chk("t6_restore", 32'(flags), 32'h2);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 4'hE, 1);
    idle(1);
    chk("t6_sat", 32'(pass_cnt), 32'd3);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
